mem_xfer_seq: RTL and testbench
===============================

# mem_xfer_seq

Memory transfer sequencer that drives the bus interface unit's buffer-control and MAR-increment strobes and the memory/I/O read/write strobes. It turns one transfer request (single word, double word, or 8-word vector, read or write) into a word-by-word sequence. Each word waits on the memory ready handshake. The block sits between the control unit and the bus interface unit, downstream of instruction decode. Its outputs replace the hand-driven `RdBuf_ld` / `WrBuf_oe` / `FPBuf_oe` / `V_RdBuf_ld` / `V_WrBuf_oe` / `MAR_inc` controls.

## Interface
Parameters:
- `WAIT_MAX`, default 15: maximum cycles spent waiting for `mem_rdy` on one word before timeout.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  start pulse; sampled only in IDLE.
- `rw`  in  1  1 = write (buffer → memory), 0 = read (memory → buffer).
- `size`  in  2  00 = single word, 01 = double word, 10 = vector (8 words), 11 = illegal.
- `src_fp`  in  1  for scalar writes, selects FP buffers (`FPBuf_oe`) instead of `WrBuf_oe`.
- `mem_rdy`  in  1  memory accepts (write) or supplies (read) the current word this cycle.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse on successful completion.
- `err`  out  1  one-cycle pulse on illegal size or timeout.
- `mem_rd`  out  1  read strobe to memory/I/O.
- `mem_wr`  out  1  write strobe to memory/I/O.
- `MAR_inc`  out  1  one-cycle MAR increment between words.
- `RdBuf_ld`  out  2  scalar read-buffer load, one-hot per word.
- `WrBuf_oe`  out  2  scalar write-buffer output enable.
- `FPBuf_oe`  out  2  FP write-buffer output enable.
- `V_RdBuf_ld`  out  8  vector read-buffer load.
- `V_WrBuf_oe`  out  8  vector write-buffer output enable.

## Operation
- States: IDLE, XFER, STEP, DONE, ERR. Registers hold the state, the latched `rw` / `size` / `src_fp`, the word index `k` (3 bits) and the wait counter.
- **IDLE**
  - `req`=1 with `size`≠11: latch `rw`/`size`/`src_fp`, set `k`=0, go to XFER.
  - `req`=1 with `size`=11: go to ERR.
  - `mem_rdy` is ignored in IDLE.
- **XFER** (all outputs decoded from state and `k`, not registered)
  - Read: `mem_rd`=1.
  - Write: `mem_wr`=1, and the write enable for word `k` is held for the whole state: `V_WrBuf_oe[k]`, or `WrBuf_oe[k]` / `FPBuf_oe[k]`.
  - Read with `mem_rdy`=1: assert the load bit for word `k` that same cycle (`RdBuf_ld[k]` or `V_RdBuf_ld[k]`).
  - On `mem_rdy`: if `k` = last word (0, 1 or 7), go to DONE; otherwise go to STEP.
- **STEP:** strobes low, `MAR_inc`=1 for exactly one cycle, `k`←`k`+1, back to XFER.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **ERR:** `err`=1 for one cycle, all strobes and enables low, then IDLE. MAR is not incremented.
- Word order is ascending: word 0 is the low word (`RdBuf_0`, `WrBuf_0`, `V_*[0]`).
- `req` while `busy`: ignored, no queuing.
- At most one enable bit is high at any time.
- The wait counter clears on entry to XFER and saturates at `WAIT_MAX`.

## Timing
- Reset (`reset`=0): state=IDLE, `k`=0, counter=0. Every output is 0 immediately and asynchronously, including mid-transfer. A partially loaded buffer is not cleaned up.
- Per word: XFER for (wait+1) cycles, where wait = cycles before `mem_rdy`; then STEP for 1 cycle on every word except the last.
- Latency from `req` to `done`, with `mem_rdy` tied high:
  - single word: 2 cycles;
  - double word: 4 cycles;
  - vector: 16 cycles.
- Timeout: `mem_rdy` still low after `WAIT_MAX` cycles in XFER → ERR on the next edge.
- `mem_rdy` and reset deassertion on the same edge: reset wins; the word is not loaded.

## Configuration
- `MEM_XFER_TIMEOUT_EN` defined: the wait counter exists and the timeout path XFER → ERR is active.
- Undefined: no counter; XFER waits indefinitely, and `WAIT_MAX` is unused. The illegal-size `err` path remains in both builds.

## Structure
- Shared package `mem_xfer_pkg`:
  - state encoding (IDLE=0, XFER=1, STEP=2, DONE=3, ERR=4);
  - size codes `SZ_WORD` / `SZ_DWORD` / `SZ_VEC` / `SZ_ILL`;
  - last-index constants 0/1/7.
- One sub-module, `xfer_wait_timer`: clear, enable, saturating count, `expired` at `WAIT_MAX`. Instantiated only under the macro.

## Test plan
- Single read, `mem_rdy`=1 in the 2nd XFER cycle → `RdBuf_ld`=01 for one cycle, no `MAR_inc`, `done` 1 cycle later; total 3 cycles from `req`.
- Double write, `src_fp`=1, `mem_rdy` high → `FPBuf_oe`=01, then a `MAR_inc` pulse, then `FPBuf_oe`=10; `done` at cycle 4; `WrBuf_oe` stays 00.
- Vector read with `mem_rdy` high → `V_RdBuf_ld` walks 01,02,…,80; 7 `MAR_inc` pulses; `done` at cycle 16.
- `size`=11 with `req` → `err` pulse next cycle; `mem_rd`/`mem_wr` never asserted.
- With the macro, `WAIT_MAX`=3, `mem_rdy` held low → `err` after 3 XFER cycles, return to IDLE. Without the macro, `busy` stays high for 100 cycles.
- `reset` low during vector write word 4 → all outputs 0 the same cycle; `req` after release starts a fresh transfer at `k`=0.

Source files
------------

// File: rtl/mem_xfer_seq_pkg.sv
// Shared types for the memory transfer sequencer: state encoding, size codes,
// per-size last word index and the latched request payload.
package mem_xfer_pkg;

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned SCALAR_W = 2;
  localparam int unsigned VEC_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_XFER = 3'd1,
    ST_STEP = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } xfer_state_e;

  typedef enum logic [1:0] {
    SZ_WORD  = 2'b00,
    SZ_DWORD = 2'b01,
    SZ_VEC   = 2'b10,
    SZ_ILL   = 2'b11
  } xfer_size_e;

  localparam logic [IDX_W-1:0] LAST_WORD  = 3'd0;
  localparam logic [IDX_W-1:0] LAST_DWORD = 3'd1;
  localparam logic [IDX_W-1:0] LAST_VEC   = 3'd7;

  typedef struct packed {
    logic       rw;
    xfer_size_e size;
    logic       src_fp;
  } xfer_req_t;

  function automatic logic [IDX_W-1:0] last_idx(input xfer_size_e sz);
    case (sz)
      SZ_DWORD: return LAST_DWORD;
      SZ_VEC:   return LAST_VEC;
      default:  return LAST_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_xfer_seq_if.sv
// Request / memory handshake / buffer-control bundle between the control unit,
// the sequencer and the bus interface unit.
interface mem_xfer_seq_if;
  import mem_xfer_pkg::*;

  logic                req;
  logic                rw;
  logic [1:0]          size;
  logic                src_fp;
  logic                mem_rdy;
  logic                busy;
  logic                done;
  logic                err;
  logic                mem_rd;
  logic                mem_wr;
  logic                MAR_inc;
  logic [SCALAR_W-1:0] RdBuf_ld;
  logic [SCALAR_W-1:0] WrBuf_oe;
  logic [SCALAR_W-1:0] FPBuf_oe;
  logic [VEC_W-1:0]    V_RdBuf_ld;
  logic [VEC_W-1:0]    V_WrBuf_oe;

  modport master (
    output req, rw, size, src_fp, mem_rdy,
    input  busy, done, err, mem_rd, mem_wr, MAR_inc,
           RdBuf_ld, WrBuf_oe, FPBuf_oe, V_RdBuf_ld, V_WrBuf_oe
  );

  modport slave (
    input  req, rw, size, src_fp, mem_rdy,
    output busy, done, err, mem_rd, mem_wr, MAR_inc,
           RdBuf_ld, WrBuf_oe, FPBuf_oe, V_RdBuf_ld, V_WrBuf_oe
  );
endinterface

// File: rtl/mem_xfer_seq_wait_timer.sv
// Per-word wait counter: cleared on XFER entry, counts waiting cycles and
// saturates at WAIT_MAX; expired flags the edge on which the count reaches it.
module xfer_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CNT_W = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_W'(WAIT_MAX))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Timeout is taken on the same edge that the count lands on WAIT_MAX.
  assign expired = en && (cnt_d == CNT_W'(WAIT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_xfer_seq.sv
// Memory transfer sequencer: one request -> word-by-word mem_rdy handshakes
// with buffer strobes. MEM_XFER_TIMEOUT_EN adds the per-word wait timeout.
module mem_xfer_seq
  import mem_xfer_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          reset,
  mem_xfer_seq_if.slave bus
);

  xfer_state_e      state_q, state_d;
  xfer_req_t        xreq_q, xreq_d;
  logic [IDX_W-1:0] k_q, k_d;

`ifdef MEM_XFER_TIMEOUT_EN
  logic tmr_clr, tmr_en, tmr_expired;

  xfer_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk     (clk),
    .rst_n   (reset),
    .clear   (tmr_clr),
    .en      (tmr_en),
    .expired (tmr_expired)
  );
`else
  // Without the timer XFER waits indefinitely and WAIT_MAX has no effect.
  logic unused_wait_max;
  assign unused_wait_max = ^WAIT_MAX;
`endif

  // Next-state, request latch and word index.
  always_comb begin
    state_d = state_q;
    xreq_d  = xreq_q;
    k_d     = k_q;
`ifdef MEM_XFER_TIMEOUT_EN
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          if (xfer_size_e'(bus.size) == SZ_ILL) begin
            state_d = ST_ERR;
          end else begin
            xreq_d  = '{rw: bus.rw, size: xfer_size_e'(bus.size), src_fp: bus.src_fp};
            k_d     = '0;
            state_d = ST_XFER;
`ifdef MEM_XFER_TIMEOUT_EN
            tmr_clr = 1'b1;
`endif
          end
        end
      end
      ST_XFER: begin
        if (bus.mem_rdy) begin
          state_d = (k_q == last_idx(xreq_q.size)) ? ST_DONE : ST_STEP;
        end else begin
`ifdef MEM_XFER_TIMEOUT_EN
          tmr_en = 1'b1;
          if (tmr_expired) state_d = ST_ERR;
`endif
        end
      end
      ST_STEP: begin
        k_d     = k_q + IDX_W'(1);
        state_d = ST_XFER;
`ifdef MEM_XFER_TIMEOUT_EN
        tmr_clr = 1'b1;
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      xreq_q  <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      xreq_q  <= xreq_d;
      k_q     <= k_d;
    end
  end

  logic                busy_c, done_c, err_c, mem_rd_c, mem_wr_c, mar_inc_c;
  logic [SCALAR_W-1:0] rd_ld_c, wr_oe_c, fp_oe_c;
  logic [VEC_W-1:0]    v_rd_ld_c, v_wr_oe_c, word_oh;
  logic                is_vec;

  assign word_oh = VEC_W'(1) << k_q;
  assign is_vec  = (xreq_q.size == SZ_VEC);

  // Strobes decode straight from state so async reset clears them at once.
  always_comb begin
    busy_c    = (state_q != ST_IDLE);
    done_c    = (state_q == ST_DONE);
    err_c     = (state_q == ST_ERR);
    mar_inc_c = (state_q == ST_STEP);
    mem_rd_c  = 1'b0;
    mem_wr_c  = 1'b0;
    rd_ld_c   = '0;
    wr_oe_c   = '0;
    fp_oe_c   = '0;
    v_rd_ld_c = '0;
    v_wr_oe_c = '0;
    if (state_q == ST_XFER) begin
      if (xreq_q.rw) begin
        mem_wr_c = 1'b1;
        if (is_vec)             v_wr_oe_c = word_oh;
        else if (xreq_q.src_fp) fp_oe_c   = word_oh[SCALAR_W-1:0];
        else                    wr_oe_c   = word_oh[SCALAR_W-1:0];
      end else begin
        mem_rd_c = 1'b1;
        if (bus.mem_rdy) begin
          if (is_vec) v_rd_ld_c = word_oh;
          else        rd_ld_c   = word_oh[SCALAR_W-1:0];
        end
      end
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.err        = err_c;
  assign bus.mem_rd     = mem_rd_c;
  assign bus.mem_wr     = mem_wr_c;
  assign bus.MAR_inc    = mar_inc_c;
  assign bus.RdBuf_ld   = rd_ld_c;
  assign bus.WrBuf_oe   = wr_oe_c;
  assign bus.FPBuf_oe   = fp_oe_c;
  assign bus.V_RdBuf_ld = v_rd_ld_c;
  assign bus.V_WrBuf_oe = v_wr_oe_c;

endmodule

// File: tb/tb_mem_xfer_seq.sv
// Scoreboard bench for mem_xfer_seq: stimulus pushes per-cycle expected
// strobe snapshots, a negedge monitor pops and compares every busy cycle.
module tb_mem_xfer_seq;
  import mem_xfer_pkg::*;

  localparam int unsigned WAIT_MAX_TB = 3;

  typedef struct packed {
    logic       done;
    logic       err;
    logic       mem_rd;
    logic       mem_wr;
    logic       mar;
    logic [1:0] rd;
    logic [1:0] wr;
    logic [1:0] fp;
    logic [7:0] vrd;
    logic [7:0] vwr;
  } snap_t;

  typedef struct {
    int unsigned cyc;
    snap_t       s;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  mem_xfer_seq_if bus();

  mem_xfer_seq #(.WAIT_MAX(WAIT_MAX_TB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        exp_q[$];
  logic        rdy_q[$];
  bit          mon_en = 1'b1;
  int unsigned last_done_cyc = 0;
  snap_t       mon_s;
  exp_t        mon_e;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.done = bus.done;     s.err = bus.err;
    s.mem_rd = bus.mem_rd; s.mem_wr = bus.mem_wr;
    s.mar = bus.MAR_inc;
    s.rd = bus.RdBuf_ld;   s.wr = bus.WrBuf_oe;  s.fp = bus.FPBuf_oe;
    s.vrd = bus.V_RdBuf_ld; s.vwr = bus.V_WrBuf_oe;
    return s;
  endfunction

  function automatic void push_exp(input int unsigned c, input snap_t s);
    exp_t e;
    e.cyc = c;
    e.s   = s;
    exp_q.push_back(e);
  endfunction

  // Monitor: every busy cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mon_en && reset) begin
      mon_s = sample();
      if (bus.busy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %0h at cycle %0d, required no activity", mon_s, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("cycle_stamp", 64'(cyc), 64'(mon_e.cyc));
          chk("outputs", 64'(mon_s), 64'(mon_e.s));
        end
        if (mon_s.done) last_done_cyc = cyc;
      end else begin
        chk("idle_outputs", 64'(mon_s), 64'(0));
      end
    end
  end

  // Expected snapshots for one transfer where every word waits wait_n cycles;
  // only the first stop_at cycles go to the scoreboard.
  task automatic build(input logic rw, input logic [1:0] sz, input logic fp,
                       input int wait_n, input int unsigned base, input int stop_at);
    int        nw;
    int        idx;
    snap_t     s;
    logic [7:0] oh;
    nw  = (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 8);
    idx = 0;
    rdy_q.delete();
    for (int k = 0; k < nw; k++) begin
      oh = 8'h01 << k[2:0];
      for (int j = 0; j <= wait_n; j++) begin
        s = '0;
        if (rw) begin
          s.mem_wr = 1'b1;
          if (sz == 2'b10) s.vwr = oh;
          else if (fp)     s.fp  = oh[1:0];
          else             s.wr  = oh[1:0];
        end else begin
          s.mem_rd = 1'b1;
          if (j == wait_n) begin
            if (sz == 2'b10) s.vrd = oh;
            else             s.rd  = oh[1:0];
          end
        end
        if (idx < stop_at) push_exp(base + idx, s);
        rdy_q.push_back(j == wait_n);
        idx++;
      end
      if (k < nw - 1) begin
        s = '0;
        s.mar = 1'b1;
        if (idx < stop_at) push_exp(base + idx, s);
        rdy_q.push_back(1'b0);
        idx++;
      end
    end
    s = '0;
    s.done = 1'b1;
    if (idx < stop_at) push_exp(base + idx, s);
    rdy_q.push_back(1'b0);
  endtask

  task automatic run_xfer(input string name, input logic rw, input logic [1:0] sz,
                          input logic fp, input int wait_n, input int exp_lat, input bit poke);
    int unsigned base;
    @(posedge clk); #1;
    base          = cyc + 1;
    last_done_cyc = 0;
    build(rw, sz, fp, wait_n, base, 1000);
    bus.req = 1'b1; bus.rw = rw; bus.size = sz; bus.src_fp = fp; bus.mem_rdy = 1'b0;
    for (int i = 0; i < rdy_q.size(); i++) begin
      @(posedge clk); #1;
      bus.req     = poke && (i == 3);
      bus.size    = (poke && (i == 3)) ? 2'b11 : sz;
      bus.mem_rdy = rdy_q[i];
    end
    bus.mem_rdy = 1'b0;
    bus.size    = 2'b00;
    @(negedge clk); #1;
    chk({name, "_latency"}, 64'(last_done_cyc - (base - 1)), 64'(exp_lat));
  endtask

  task automatic run_illegal(input logic rw);
    snap_t s;
    @(posedge clk); #1;
    s = '0;
    s.err = 1'b1;
    push_exp(cyc + 1, s);
    bus.req = 1'b1; bus.rw = rw; bus.size = 2'b11; bus.mem_rdy = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0; bus.size = 2'b00;
    @(posedge clk); #1;
    bus.mem_rdy = 1'b0;
  endtask

  task automatic run_timeout();
    snap_t       s;
    int unsigned base;
    int          busy_cnt;
    @(posedge clk); #1;
    base = cyc + 1;
    bus.req = 1'b1; bus.rw = 1'b0; bus.size = 2'b00; bus.src_fp = 1'b0; bus.mem_rdy = 1'b0;
`ifdef MEM_XFER_TIMEOUT_EN
    busy_cnt = 0;
    for (int i = 0; i < int'(WAIT_MAX_TB); i++) begin
      s = '0;
      s.mem_rd = 1'b1;
      push_exp(base + i, s);
    end
    s = '0;
    s.err = 1'b1;
    push_exp(base + WAIT_MAX_TB, s);
    for (int i = 0; i < int'(WAIT_MAX_TB) + 2; i++) begin
      @(posedge clk); #1;
      bus.req = 1'b0;
    end
    @(negedge clk); #1;
    chk("timeout_back_to_idle", 64'(bus.busy), 64'(0));
`else
    mon_en   = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      bus.req = 1'b0;
      if (bus.busy) busy_cnt++;
    end
    chk("no_timeout_busy_cycles", 64'(busy_cnt), 64'(100));
    reset = 1'b0;
    @(posedge clk); #1;
    reset  = 1'b1;
    mon_en = 1'b1;
`endif
  endtask

  // Reset while vector write word 4 is on the bus, then a fresh transfer.
  task automatic run_reset_mid();
    int unsigned base;
    @(posedge clk); #1;
    base = cyc + 1;
    build(1'b1, 2'b10, 1'b0, 0, base, 8);
    bus.req = 1'b1; bus.rw = 1'b1; bus.size = 2'b10; bus.src_fp = 1'b0; bus.mem_rdy = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.req     = 1'b0;
      bus.mem_rdy = rdy_q[i];
    end
    @(posedge clk); #1;
    chk("rst_word4_v_wr_oe", 64'(bus.V_WrBuf_oe), 64'(8'h10));
    chk("rst_word4_mem_wr", 64'(bus.mem_wr), 64'(1));
    bus.mem_rdy = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_async_outputs", 64'(sample()), 64'(0));
    chk("rst_async_busy", 64'(bus.busy), 64'(0));
    bus.mem_rdy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  initial begin
    bus.req = 1'b0; bus.rw = 1'b0; bus.size = 2'b00; bus.src_fp = 1'b0; bus.mem_rdy = 1'b0;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.mem_rdy = 1'b1;
    #1;
    chk("reset_outputs", 64'(sample()), 64'(0));
    chk("reset_busy", 64'(bus.busy), 64'(0));
    bus.mem_rdy = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    run_xfer("single_rd_wait1", 1'b0, 2'b00, 1'b0, 1, 3, 1'b0);
    run_xfer("double_wr_fp", 1'b1, 2'b01, 1'b1, 0, 4, 1'b0);
    run_xfer("vec_rd_poke", 1'b0, 2'b10, 1'b0, 0, 16, 1'b1);
    run_xfer("single_wr", 1'b1, 2'b00, 1'b0, 0, 2, 1'b0);
    run_xfer("double_rd_wait2", 1'b0, 2'b01, 1'b0, 2, 8, 1'b0);
    run_illegal(1'b0);
    run_illegal(1'b1);
    run_timeout();
    run_reset_mid();
    run_xfer("vec_wr_after_rst", 1'b1, 2'b10, 1'b0, 0, 16, 1'b0);

    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
